// File: rtl/ps2_mouse_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : ps2_mouse_tracker                                               |
// | Brief  : PS/2 mouse receiver, 3-byte packet assembler, clamped cursor.   |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module ps2_mouse_tracker #(
    parameter int CANVAS_WIDTH   = 360,
    parameter int CANVAS_HEIGHT  = 720,
    parameter int INIT_X         = 180,
    parameter int INIT_Y         = 360,
    parameter int SPEED_SHIFT    = 0,
    parameter int INVERT_Y       = 0,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                             clk_in,
    input  logic                             rst_n_in,
    input  logic                             clk_ps2_raw,
    input  logic                             ps2_data,
    input  logic                             recenter_in,
    output logic [$clog2(CANVAS_WIDTH)-1:0]  mouse_x,
    output logic [$clog2(CANVAS_HEIGHT)-1:0] mouse_y,
    output logic [2:0]                       buttons,
    output logic                             left_click,
    output logic                             right_click,
    output logic                             packet_valid,
    output logic                             frame_err
);

    localparam int c_x_w  = $clog2(CANVAS_WIDTH);
    localparam int c_y_w  = $clog2(CANVAS_HEIGHT);
    // Never narrower than 11 bits so a -256/+256 delta always fits.
    localparam int c_xs_w = (c_x_w + 2 > 11) ? c_x_w + 2 : 11;
    localparam int c_ys_w = (c_y_w + 2 > 11) ? c_y_w + 2 : 11;
    localparam int c_to_w = ($clog2(TIMEOUT_CYCLES) > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic signed [c_xs_w-1:0] c_x_max  = c_xs_w'(CANVAS_WIDTH - 1);
    localparam logic signed [c_ys_w-1:0] c_y_max  = c_ys_w'(CANVAS_HEIGHT - 1);
    localparam logic [c_x_w-1:0]         c_init_x = c_x_w'(INIT_X);
    localparam logic [c_y_w-1:0]         c_init_y = c_y_w'(INIT_Y);
    localparam logic [c_to_w-1:0]        c_to_max = c_to_w'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [SYNC_STAGES-1:0]   clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0]   data_sync_q, data_sync_d;
    logic                     clk_prev_q, clk_prev_d;
    logic [2:0]               bit_cnt_q, bit_cnt_d;
    logic [7:0]               shift_q, shift_d;
    logic [1:0]               byte_idx_q, byte_idx_d;
    logic [6:0]               hdr_q, hdr_d;
    logic [7:0]               xmag_q, xmag_d;
    logic [c_to_w-1:0]        to_cnt_q, to_cnt_d;
    logic [c_x_w-1:0]         mouse_x_q, mouse_x_d;
    logic [c_y_w-1:0]         mouse_y_q, mouse_y_d;
    logic [2:0]               buttons_q, buttons_d;
    logic                     lclick_q, lclick_d;
    logic                     rclick_q, rclick_d;
    logic                     pvalid_q, pvalid_d;
    logic                     ferr_q, ferr_d;

    logic                     w_clk_s;
    logic                     w_bit;
    logic                     w_fall;
    logic                     w_pkt_done;
    logic signed [8:0]        w_dx9;
    logic signed [8:0]        w_dy9;
    logic signed [c_xs_w-1:0] w_dx;
    logic signed [c_ys_w-1:0] w_dy;
    logic signed [c_xs_w-1:0] w_sum_x;
    logic signed [c_ys_w-1:0] w_sum_y;
    logic [c_x_w-1:0]         w_new_x;
    logic [c_y_w-1:0]         w_new_y;

    // hdr_q layout: {Yovf, Xovf, Ysign, Xsign, M, R, L}
    function automatic logic signed [8:0] decode_delta(input logic sgn, input logic ovf,
                                                       input logic [7:0] mag);
        logic signed [8:0] d;
        if (ovf) d = sgn ? $signed(9'h100) : $signed(9'h0FF);
        else     d = $signed({sgn, mag});
        return d >>> SPEED_SHIFT;
    endfunction

    assign w_clk_s = clk_sync_q[SYNC_STAGES-1];
    assign w_bit   = data_sync_q[SYNC_STAGES-1];
    assign w_fall  = clk_prev_q & ~w_clk_s;

    always_comb begin
        w_dx9   = decode_delta(hdr_q[3], hdr_q[5], xmag_q);
        w_dy9   = decode_delta(hdr_q[4], hdr_q[6], shift_q);
        w_dx    = {{(c_xs_w-9){w_dx9[8]}}, w_dx9};
        w_dy    = {{(c_ys_w-9){w_dy9[8]}}, w_dy9};
        if (INVERT_Y != 0) w_dy = -w_dy;
        w_sum_x = $signed({{(c_xs_w-c_x_w){1'b0}}, mouse_x_q}) + w_dx;
        w_sum_y = $signed({{(c_ys_w-c_y_w){1'b0}}, mouse_y_q}) + w_dy;
        if (w_sum_x < 0)             w_new_x = '0;
        else if (w_sum_x > c_x_max)  w_new_x = c_x_max[c_x_w-1:0];
        else                         w_new_x = w_sum_x[c_x_w-1:0];
        if (w_sum_y < 0)             w_new_y = '0;
        else if (w_sum_y > c_y_max)  w_new_y = c_y_max[c_y_w-1:0];
        else                         w_new_y = w_sum_y[c_y_w-1:0];
    end

    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], clk_ps2_raw};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
        clk_prev_d  = w_clk_s;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        byte_idx_d  = byte_idx_q;
        hdr_d       = hdr_q;
        xmag_d      = xmag_q;
        to_cnt_d    = to_cnt_q;
        mouse_x_d   = mouse_x_q;
        mouse_y_d   = mouse_y_q;
        buttons_d   = buttons_q;
        lclick_d    = 1'b0;
        rclick_d    = 1'b0;
        pvalid_d    = 1'b0;
        ferr_d      = 1'b0;
        w_pkt_done  = 1'b0;

        if (w_fall) begin
            to_cnt_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (!w_bit) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {w_bit, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    if (^{shift_q, w_bit}) begin
                        state_d = ST_STOP;
                    end else begin
                        state_d    = ST_IDLE;
                        byte_idx_d = 2'd0;
                        ferr_d     = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    if (!w_bit) begin
                        byte_idx_d = 2'd0;
                        ferr_d     = 1'b1;
                    end else begin
                        case (byte_idx_q)
                            2'd0: begin
                                // Bit 3 is always set in a header; otherwise resync.
                                if (shift_q[3]) begin
                                    hdr_d      = {shift_q[7:4], shift_q[2:0]};
                                    byte_idx_d = 2'd1;
                                end
                            end
                            2'd1: begin
                                xmag_d     = shift_q;
                                byte_idx_d = 2'd2;
                            end
                            default: begin
                                byte_idx_d = 2'd0;
                                w_pkt_done = 1'b1;
                            end
                        endcase
                    end
                end
            endcase
        end else if (state_q != ST_IDLE || byte_idx_q != 2'd0) begin
            if (to_cnt_q == c_to_max) begin
                state_d    = ST_IDLE;
                byte_idx_d = 2'd0;
                to_cnt_d   = '0;
                ferr_d     = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + c_to_w'(1);
            end
        end else begin
            to_cnt_d = '0;
        end

        if (w_pkt_done) begin
            mouse_x_d = w_new_x;
            mouse_y_d = w_new_y;
            buttons_d = hdr_q[2:0];
            lclick_d  = hdr_q[0] & ~buttons_q[0];
            rclick_d  = hdr_q[1] & ~buttons_q[1];
            pvalid_d  = 1'b1;
        end
        if (recenter_in) begin
            mouse_x_d = c_init_x;
            mouse_y_d = c_init_y;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            byte_idx_q  <= 2'd0;
            hdr_q       <= 7'd0;
            xmag_q      <= 8'd0;
            to_cnt_q    <= '0;
            mouse_x_q   <= c_init_x;
            mouse_y_q   <= c_init_y;
            buttons_q   <= 3'd0;
            lclick_q    <= 1'b0;
            rclick_q    <= 1'b0;
            pvalid_q    <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            byte_idx_q  <= byte_idx_d;
            hdr_q       <= hdr_d;
            xmag_q      <= xmag_d;
            to_cnt_q    <= to_cnt_d;
            mouse_x_q   <= mouse_x_d;
            mouse_y_q   <= mouse_y_d;
            buttons_q   <= buttons_d;
            lclick_q    <= lclick_d;
            rclick_q    <= rclick_d;
            pvalid_q    <= pvalid_d;
            ferr_q      <= ferr_d;
        end
    end

    assign mouse_x      = mouse_x_q;
    assign mouse_y      = mouse_y_q;
    assign buttons      = buttons_q;
    assign left_click   = lclick_q;
    assign right_click  = rclick_q;
    assign packet_valid = pvalid_q;
    assign frame_err    = ferr_q;

endmodule
`default_nettype wire
